// File: rtl/stream_fifo_pkg.sv
// -----------------------------------------------------------------------------
// stream_fifo_pkg
//   Shared definitions for the stream FIFO and other buffers built on the same
//   pointer scheme.
//
//   fifo_ptr_w(addr_w)  width of a read/write pointer: one extra wrap bit so a
//                       full buffer can be told apart from an empty one.
//   fifo_status_t       packed bundle of occupancy and sticky error flags.
// -----------------------------------------------------------------------------
package stream_fifo_pkg;

    function automatic int unsigned fifo_ptr_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/stream_fifo_if.sv
// -----------------------------------------------------------------------------
// stream_fifo_if
//   Producer/consumer bundle for stream_fifo.
//
//   Signals (driven by the master = producer/consumer logic):
//     flush         synchronous clear of pointers, count and error flags
//     WE, data_in   write request and write data
//     RE            read request
//   Signals (driven by the slave = the FIFO):
//     data_out      read data
//     rd_valid      data_out holds a word popped by an accepted read
//     empty, full, almost_empty, almost_full   occupancy flags
//     count         current occupancy, 0..2**ADDR_W
//     overflow, underflow   sticky error flags
// -----------------------------------------------------------------------------
interface stream_fifo_if
    import stream_fifo_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned ADDR_W = 5
);

    logic                               flush;
    logic                               WE;
    logic [W-1:0]                       data_in;
    logic                               RE;
    logic [W-1:0]                       data_out;
    logic                               rd_valid;
    logic                               empty;
    logic                               full;
    logic                               almost_empty;
    logic                               almost_full;
    logic [fifo_ptr_w(ADDR_W)-1:0]      count;
    logic                               overflow;
    logic                               underflow;

    modport master (
        output flush, WE, data_in, RE,
        input  data_out, rd_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  flush, WE, data_in, RE,
        output data_out, rd_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

endinterface

// File: rtl/stream_fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
//   Simple dual-port storage array, W x 2**ADDR_W, for stream_fifo.
//   Write port is synchronous. The read port depends on STREAM_FIFO_FWFT_EN:
//     undefined : synchronous read; rdata loads mem[raddr] on an edge with re
//                 and holds otherwise. Only the read register is reset.
//     defined   : asynchronous read; rdata = mem[raddr] at all times.
//   The array itself is never reset.
//
//   Ports: clk, reset (async, active-high), we/waddr/wdata (write port),
//          re/raddr/rdata (read port).
// -----------------------------------------------------------------------------
module fifo_ram
    import stream_fifo_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [W-1:0] mem [0:Depth-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef STREAM_FIFO_FWFT_EN
    assign rdata = mem[raddr];

    // The combinational read port needs neither the enable nor the reset.
    logic unused_rd;
    assign unused_rd = ^{re, reset};
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
//   Synchronous FIFO for byte/word streams on one clock. Holds all 2**ADDR_W
//   entries, tracks occupancy, raises programmable almost-flags and latches
//   sticky overflow/underflow until flush or reset.
//
//   Parameters: W (data width), ADDR_W (depth = 2**ADDR_W),
//               AF_THRESH (almost_full when count >= AF_THRESH),
//               AE_THRESH (almost_empty when count <= AE_THRESH).
//   Ports:      clk, reset (async, active-high), bus (stream_fifo_if.slave).
//
//   Build option STREAM_FIFO_FWFT_EN:
//     undefined : data_out registered, rd_valid pulses the cycle after a pop.
//     defined   : first-word-fall-through; data_out shows the head word
//                 (0 when empty), rd_valid = ~empty, RE pops the shown word.
//   Flags, count and error behaviour are the same in both modes.
// -----------------------------------------------------------------------------
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned AF_THRESH = (2 ** ADDR_W) - 2,
    parameter int unsigned AE_THRESH = 1
) (
    input logic          clk,
    input logic          reset,
    stream_fifo_if.slave bus
);

    localparam int unsigned      PtrW   = fifo_ptr_w(ADDR_W);
    localparam logic [PtrW-1:0]  PtrOne = PtrW'(1);
    localparam logic [ADDR_W:0]  AfThr  = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0]  AeThr  = (ADDR_W + 1)'(AE_THRESH);

    logic [PtrW-1:0] wp_q, wp_d;
    logic [PtrW-1:0] rp_q, rp_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;

    fifo_status_t    status;
    logic            rd_ok;
    logic            wr_ok;
    logic [W-1:0]    ram_rdata;

    // Occupancy flags come straight from the registered state.
    always_comb begin
        status              = '0;
        status.empty        = (wp_q == rp_q);
        status.full         = (wp_q[ADDR_W] != rp_q[ADDR_W]) &&
                              (wp_q[ADDR_W-1:0] == rp_q[ADDR_W-1:0]);
        status.almost_empty = (count_q <= AeThr);
        status.almost_full  = (count_q >= AfThr);
        status.overflow     = ovf_q;
        status.underflow    = udf_q;
    end

    // A write at full only goes in when a read frees a slot in the same cycle.
    // On empty the read is refused, so a simultaneous write is never bypassed.
    assign rd_ok = bus.RE & ~status.empty;
    assign wr_ok = bus.WE & (~status.full | rd_ok);

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q | (bus.WE & ~wr_ok);
        udf_d   = udf_q | (bus.RE & status.empty);

        if (wr_ok) begin
            wp_d = wp_q + PtrOne;
        end
        if (rd_ok) begin
            rp_d = rp_q + PtrOne;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + PtrOne;
            2'b01:   count_d = count_q - PtrOne;
            default: count_d = count_q;
        endcase

        // Flush overrides any request in the same cycle.
        if (bus.flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_ram #(
        .W      (W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_ok & ~bus.flush),
        .waddr (wp_q[ADDR_W-1:0]),
        .wdata (bus.data_in),
        .re    (rd_ok & ~bus.flush),
        .raddr (rp_q[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

`ifdef STREAM_FIFO_FWFT_EN
    assign bus.data_out = status.empty ? '0 : ram_rdata;
    assign bus.rd_valid = ~status.empty;
`else
    logic rd_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok & ~bus.flush;
        end
    end

    assign bus.data_out = ram_rdata;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.empty        = status.empty;
    assign bus.full         = status.full;
    assign bus.almost_empty = status.almost_empty;
    assign bus.almost_full  = status.almost_full;
    assign bus.overflow     = status.overflow;
    assign bus.underflow    = status.underflow;
    assign bus.count        = count_q;

endmodule

// File: tb/tb_stream_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_fifo
//   Directed bench for stream_fifo at W=8, ADDR_W=2 (depth 4), AF_THRESH=3,
//   AE_THRESH=1. Written words are queued as expected read data; a monitor on
//   the falling edge pops and compares whenever the FIFO presents a word.
//   Flags and count are checked directly after each clock.
// -----------------------------------------------------------------------------
module tb_stream_fifo;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];

    stream_fifo_if #(.W(8), .ADDR_W(2)) bus ();

    stream_fifo #(
        .W         (8),
        .ADDR_W    (2),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d);
        exp_q.push_back(d);
    endtask

    // Scoreboard monitor: compares every word the FIFO hands out.
    always @(negedge clk) begin
        if (!reset) begin
`ifdef STREAM_FIFO_FWFT_EN
            if (bus.RE && bus.rd_valid) begin
`else
            if (bus.rd_valid) begin
`endif
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_data: got 0x%0h, expected no word at %0t",
                             bus.data_out, $time);
                end else begin
                    check("rd_data", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #100000;
        checks++;
        failures++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    logic [7:0] fill [4];
    logic [2:0] cnt_exp [4];
    logic       af_exp  [4];
    logic       ae_exp  [4];
    logic       full_exp[4];

    initial begin
        fill     = '{8'h11, 8'h22, 8'h33, 8'h44};
        cnt_exp  = '{3'd1, 3'd2, 3'd3, 3'd4};
        af_exp   = '{1'b0, 1'b0, 1'b1, 1'b1};
        ae_exp   = '{1'b1, 1'b0, 1'b0, 1'b0};
        full_exp = '{1'b0, 1'b0, 1'b0, 1'b1};

        bus.flush   = 1'b0;
        bus.WE      = 1'b0;
        bus.RE      = 1'b0;
        bus.data_in = 8'h00;

        // Reset state
        #12;
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_underflow", bus.underflow, 0);
        check("rst_almost_empty", bus.almost_empty, 1);
        check("rst_almost_full", bus.almost_full, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1. Fill to full
        for (int i = 0; i < 4; i++) begin
            bus.WE      = 1'b1;
            bus.data_in = fill[i];
            push_exp(fill[i]);
            tick();
            check("fill_count", bus.count, cnt_exp[i]);
            check("fill_almost_full", bus.almost_full, af_exp[i]);
            check("fill_almost_empty", bus.almost_empty, ae_exp[i]);
            check("fill_full", bus.full, full_exp[i]);
        end
        check("fill_overflow", bus.overflow, 0);

        // 2. Write at full refused; write+read at full accepted
        bus.data_in = 8'h55;
        tick();
        check("ovf_count", bus.count, 4);
        check("ovf_flag", bus.overflow, 1);
        bus.RE      = 1'b1;
        bus.data_in = 8'h66;
        push_exp(8'h66);
        tick();
        check("wr_rd_full_count", bus.count, 4);
        check("wr_rd_full_full", bus.full, 1);
        check("ovf_sticky", bus.overflow, 1);
`ifndef STREAM_FIFO_FWFT_EN
        check("wr_rd_full_rd_valid", bus.rd_valid, 1);
`endif

        // 3. Drain
        bus.WE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_count", bus.count, 3 - i);
`ifndef STREAM_FIFO_FWFT_EN
            check("drain_rd_valid", bus.rd_valid, 1);
`endif
        end
        bus.RE = 1'b0;
        tick();
        check("drained_empty", bus.empty, 1);
        check("drained_rd_valid", bus.rd_valid, 0);
        bus.RE = 1'b1;
        tick();
        bus.RE = 1'b0;
        check("udf_flag", bus.underflow, 1);
        check("udf_count", bus.count, 0);
        check("udf_rd_valid", bus.rd_valid, 0);
`ifdef STREAM_FIFO_FWFT_EN
        check("udf_data_out", bus.data_out, 8'h00);
`else
        check("udf_data_out", bus.data_out, 8'h66);
`endif
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush1_overflow", bus.overflow, 0);
        check("flush1_underflow", bus.underflow, 0);

        // 4. Continuous push/pop across pointer wrap at count 1
        bus.WE      = 1'b1;
        bus.data_in = 8'h80;
        push_exp(8'h80);
        tick();
        check("wrap_prime_count", bus.count, 1);
        bus.RE = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            bus.data_in = 8'h80 + 8'(k);
            push_exp(8'h80 + 8'(k));
            tick();
            check("wrap_count", bus.count, 1);
            check("wrap_flags", {bus.overflow, bus.underflow, bus.full, bus.empty}, 4'b0000);
        end
        bus.WE = 1'b0;
        tick();
        bus.RE = 1'b0;
        check("wrap_end_count", bus.count, 0);
        tick();

        // 5. Flush at count 3 with overflow set and WE asserted
        bus.WE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.data_in = 8'hA1 + 8'(i);
            push_exp(8'hA1 + 8'(i));
            tick();
        end
        bus.data_in = 8'hA5;
        tick();
        bus.WE = 1'b0;
        bus.RE = 1'b1;
        tick();
        bus.RE = 1'b0;
        check("pre_flush_count", bus.count, 3);
        check("pre_flush_overflow", bus.overflow, 1);
        bus.flush   = 1'b1;
        bus.WE      = 1'b1;
        bus.data_in = 8'hEE;
        tick();
        bus.flush = 1'b0;
        bus.WE    = 1'b0;
        check("flush_count", bus.count, 0);
        check("flush_empty", bus.empty, 1);
        check("flush_overflow", bus.overflow, 0);
        check("flush_rd_valid", bus.rd_valid, 0);
`ifdef STREAM_FIFO_FWFT_EN
        check("flush_data_out", bus.data_out, 8'h00);
`else
        check("flush_data_out", bus.data_out, 8'hA1);
`endif
        exp_q.delete();
        tick();
        check("flush_write_ignored", bus.count, 0);

        // 6. Asynchronous reset mid-burst
        bus.WE      = 1'b1;
        bus.data_in = 8'h11;
        tick();
`ifdef STREAM_FIFO_FWFT_EN
        check("fwft_data_out", bus.data_out, 8'h11);
        check("fwft_rd_valid", bus.rd_valid, 1);
`else
        check("std_no_rd_valid", bus.rd_valid, 0);
`endif
        bus.data_in = 8'h22;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", bus.count, 0);
        check("arst_empty", bus.empty, 1);
        check("arst_full", bus.full, 0);
        check("arst_data_out", bus.data_out, 0);
        check("arst_rd_valid", bus.rd_valid, 0);
        bus.WE = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;

        // Post-reset sanity transfer
        bus.WE      = 1'b1;
        bus.data_in = 8'h5A;
        push_exp(8'h5A);
        tick();
        bus.WE = 1'b0;
        bus.RE = 1'b1;
        tick();
        bus.RE = 1'b0;
        tick();
        tick();
        check("post_rst_empty", bus.empty, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
